// File: rtl/bp_pkg.sv
// Shared definitions for the Bus Pirate byte engine: pin positions on the
// bp_din/bp_dout buses and the transfer state encoding.
package bp_pkg;

  // Pin positions on the pin buses.
  localparam int PIN_MOSI = 0;
  localparam int PIN_SCLK = 1;
  localparam int PIN_CS   = 2;
  localparam int PIN_MISO = 3;

  // Bits per transfer; the bit index counts down from BYTE_MSB to 0.
  localparam logic [2:0] BYTE_MSB = 3'd7;

  // IDLE: no transfer, LOW: SCLK low half-period, HIGH: SCLK high half-period.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } bp_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period timer for SCLK. While i_run is high it counts system clocks
// and raises o_tick on the last cycle of each HALF_PERIOD window. The count
// is held at zero whenever i_run is low, so every transfer starts with a
// full-length first half-period.
module sclk_tick_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_cnt;

  // Count within the half-period window; wrap after the last cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/peripheral_facade.sv
// Byte-wide SPI mode-0 engine between the command dispatcher and the Bus
// Pirate pin buffers. A go pulse in IDLE starts one full-duplex 8-bit
// transfer, MSB first. The received byte appears on out_data together with
// a one-cycle data_ready strobe, in the same cycle that state drops.
//
// Handshake: go is a single-cycle request honoured only while the engine is
// idle (state=0, which includes the data_ready cycle); in_data is sampled on
// that accepted edge only. data_ready is a one-cycle valid strobe with no
// back-pressure: the consumer must take out_data in that cycle, although
// out_data itself holds until the next completion.
module peripheral_facade
  import bp_pkg::*;
#(
  parameter int BP_PINS     = 5,
  parameter int HALF_PERIOD = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_data,
  output logic [7:0]         out_data,
  input  logic               go,
  output logic               state,
  output logic               data_ready,
  output logic [BP_PINS-1:0] bp_din,
  input  logic [BP_PINS-1:0] bp_dout
);

  // Registered state and datapath.
  bp_state_e  r_fsm;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_bit_idx;
  logic       r_mosi;
  logic       r_sclk;
  logic       r_cs_n;
  logic       r_busy;
  logic [7:0] r_out;
  logic       r_dr;

  // Next-state values computed by the FSM.
  bp_state_e  w_nxt_fsm;
  logic [7:0] w_nxt_tx;
  logic [7:0] w_nxt_rx;
  logic [2:0] w_nxt_bit_idx;
  logic       w_nxt_mosi;
  logic       w_nxt_sclk;
  logic       w_nxt_cs_n;
  logic       w_nxt_busy;
  logic [7:0] w_nxt_out;
  logic       w_nxt_dr;

  logic       w_run;
  logic       w_tick;
  logic [2:0] w_idx_m1;
  logic       w_miso;
  logic       w_unused_pins;

  assign w_run    = (r_fsm != IDLE);
  assign w_idx_m1 = r_bit_idx - 3'd1;
  assign w_miso   = bp_dout[PIN_MISO];

  // Only MISO is read back; the remaining read-back pins are don't-care.
  assign w_unused_pins = ^bp_dout;

  sclk_tick_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_tick (
    .i_clk   (clock),
    .i_reset (reset),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_nxt_fsm;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_nxt_fsm     = r_fsm;
    w_nxt_tx      = r_tx;
    w_nxt_rx      = r_rx;
    w_nxt_bit_idx = r_bit_idx;
    w_nxt_mosi    = r_mosi;
    w_nxt_sclk    = r_sclk;
    w_nxt_cs_n    = r_cs_n;
    w_nxt_busy    = r_busy;
    w_nxt_out     = r_out;
    w_nxt_dr      = 1'b0;

    case (r_fsm)
      IDLE: begin
        if (go) begin
          w_nxt_tx      = in_data;
          w_nxt_rx      = '0;
          w_nxt_mosi    = in_data[7];
          w_nxt_sclk    = 1'b0;
          w_nxt_cs_n    = 1'b0;
          w_nxt_busy    = 1'b1;
          w_nxt_bit_idx = BYTE_MSB;
          w_nxt_fsm     = LOW;
        end
      end

      LOW: begin
        // Rising SCLK edge: sample MISO into the receive register LSB.
        if (w_tick) begin
          w_nxt_sclk = 1'b1;
          w_nxt_rx   = {r_rx[6:0], w_miso};
          w_nxt_fsm  = HIGH;
        end
      end

      HIGH: begin
        if (w_tick) begin
          w_nxt_sclk = 1'b0;
          if (r_bit_idx != 3'd0) begin
            // Falling SCLK edge: present the next lower bit on MOSI.
            w_nxt_mosi    = r_tx[w_idx_m1];
            w_nxt_bit_idx = w_idx_m1;
            w_nxt_fsm     = LOW;
          end else begin
            // Last bit done: release the bus and hand the byte over.
            w_nxt_cs_n = 1'b1;
            w_nxt_mosi = 1'b0;
            w_nxt_busy = 1'b0;
            w_nxt_out  = r_rx;
            w_nxt_dr   = 1'b1;
            w_nxt_fsm  = IDLE;
          end
        end
      end

      default: begin
        w_nxt_fsm = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_idx <= '0;
      r_mosi    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_out     <= '0;
      r_dr      <= 1'b0;
    end else begin
      r_tx      <= w_nxt_tx;
      r_rx      <= w_nxt_rx;
      r_bit_idx <= w_nxt_bit_idx;
      r_mosi    <= w_nxt_mosi;
      r_sclk    <= w_nxt_sclk;
      r_cs_n    <= w_nxt_cs_n;
      r_busy    <= w_nxt_busy;
      r_out     <= w_nxt_out;
      r_dr      <= w_nxt_dr;
    end
  end

  // Pin bus assembly from registers; unused upper pins drive 0.
  always_comb begin
    bp_din           = '0;
    bp_din[PIN_MOSI] = r_mosi;
    bp_din[PIN_SCLK] = r_sclk;
    bp_din[PIN_CS]   = r_cs_n;
  end

  assign out_data   = r_out;
  assign state      = r_busy;
  assign data_ready = r_dr;

endmodule

// File: tb/tb_peripheral_facade.sv
// Self-checking bench for peripheral_facade. Expected bytes are queued when a
// go is driven and popped when data_ready is seen.
module tb_peripheral_facade;

  localparam int HP   = 2;
  localparam int PINS = 5;
  localparam logic [PINS-1:0] PINS_RESET = PINS'(5'b00100);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in_data = 8'h00;
  logic [7:0]       out_data;
  logic             go = 1'b0;
  logic             state;
  logic             data_ready;
  logic [PINS-1:0]  bp_din;
  logic [PINS-1:0]  bp_dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // MISO source: 0 = loopback of MOSI, 1 = constant 1, 2 = serial pattern.
  int         miso_mode = 0;
  logic [7:0] miso_pat  = 8'h00;

  // Monitor counters, updated on the falling edge.
  int         sclk_rises   = 0;
  int         xfer_rise    = 0;
  int         dr_pulses    = 0;
  int         mosi_high    = 0;
  int         cs_high_busy = 0;
  int         run_len      = 0;
  int         last_run     = 0;
  logic       prev_sclk    = 1'b0;
  logic [7:0] mosi_stream  = 8'h00;

  peripheral_facade #(
    .BP_PINS     (PINS),
    .HALF_PERIOD (HP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .out_data   (out_data),
    .go         (go),
    .state      (state),
    .data_ready (data_ready),
    .bp_din     (bp_din),
    .bp_dout    (bp_dout)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- MISO source ----------------
  always_comb begin
    bp_dout = '0;
    case (miso_mode)
      0:       bp_dout[3] = bp_din[0];
      1:       bp_dout[3] = 1'b1;
      default: bp_dout[3] = (xfer_rise < 8) ? miso_pat[3'(7 - xfer_rise)] : 1'b0;
    endcase
  end

  // ---------------- pin monitor ----------------
  always @(negedge clock) begin
    if (bp_din[1] && !prev_sclk) begin
      sclk_rises  <= sclk_rises + 1;
      mosi_stream <= {mosi_stream[6:0], bp_din[0]};
    end
    if (!state) begin
      xfer_rise <= 0;
    end else if (bp_din[1] && !prev_sclk) begin
      xfer_rise <= xfer_rise + 1;
    end
    prev_sclk <= bp_din[1];
    if (state) begin
      run_len <= run_len + 1;
      if (bp_din[0]) mosi_high <= mosi_high + 1;
      if (bp_din[2]) cs_high_busy <= cs_high_busy + 1;
    end else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
    if (data_ready) dr_pulses <= dr_pulses + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_go(input logic [7:0] d, input logic [7:0] exp);
    in_data = d;
    go      = 1'b1;
    exp_q.push_back(exp);
    tick();
    go      = 1'b0;
  endtask

  task automatic wait_dr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    go = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", state); end
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_dr got %b exp 0", data_ready); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", out_data); end
    checks++;
    if (bp_din !== PINS_RESET) begin errors++; $display("FAIL reset_pins got %b exp %b", bp_din, PINS_RESET); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    bit ok;
    int r0;
    logic [7:0] exp;
    miso_mode = 0;
    r0 = dr_pulses;
    do_go(8'hA5, 8'hA5);
    wait_dr(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL loop_timeout got no data_ready exp strobe");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("FAIL loop_data got %h exp %h", out_data, exp); end
      checks++;
      if (state !== 1'b0) begin errors++; $display("FAIL loop_state_at_dr got %b exp 0", state); end
    end
    tick();
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL loop_dr_width got %b exp 0", data_ready); end
    tick();
    checks++;
    if (last_run !== 16 * HP) begin errors++; $display("FAIL loop_busy_len got %0d exp %0d", last_run, 16 * HP); end
    checks++;
    if (dr_pulses - r0 !== 1) begin errors++; $display("FAIL loop_dr_count got %0d exp 1", dr_pulses - r0); end
  endtask

  task automatic test_miso_one();
    bit ok;
    int r_rise, r_mosi, r_cs;
    logic [7:0] exp;
    miso_mode = 1;
    r_rise = sclk_rises;
    r_mosi = mosi_high;
    r_cs   = cs_high_busy;
    do_go(8'h00, 8'hFF);
    wait_dr(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ones_timeout got no data_ready exp strobe");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("FAIL ones_data got %h exp %h", out_data, exp); end
    end
    tick();
    checks++;
    if (sclk_rises - r_rise !== 8) begin errors++; $display("FAIL ones_sclk_rises got %0d exp 8", sclk_rises - r_rise); end
    checks++;
    if (mosi_high - r_mosi !== 0) begin errors++; $display("FAIL ones_mosi_low got %0d high cycles exp 0", mosi_high - r_mosi); end
    checks++;
    if (cs_high_busy - r_cs !== 0) begin errors++; $display("FAIL ones_cs_low got %0d high cycles exp 0", cs_high_busy - r_cs); end
  endtask

  task automatic test_pattern();
    bit ok;
    logic [7:0] exp;
    miso_mode = 2;
    miso_pat  = 8'hB2;
    do_go(8'h5A, 8'hB2);
    wait_dr(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL pat_timeout got no data_ready exp strobe");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("FAIL pat_data got %h exp %h", out_data, exp); end
    end
    tick();
  endtask

  task automatic test_busy();
    bit ok;
    int r0;
    logic [7:0] exp;
    miso_mode = 0;
    r0 = dr_pulses;
    do_go(8'h3C, 8'h3C);
    repeat (8) tick();
    in_data = 8'hFF;
    go = 1'b1;
    tick();
    go = 1'b0;
    in_data = 8'h00;
    wait_dr(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL busy_timeout got no data_ready exp strobe");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("FAIL busy_data got %h exp %h", out_data, exp); end
    end
    tick();
    checks++;
    if (mosi_stream !== 8'h3C) begin errors++; $display("FAIL busy_mosi_stream got %b exp 00111100", mosi_stream); end
    repeat (40) tick();
    checks++;
    if (dr_pulses - r0 !== 1) begin errors++; $display("FAIL busy_dr_count got %0d exp 1", dr_pulses - r0); end
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL busy_idle got %b exp 0", state); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp;
    miso_mode = 0;
    do_go(8'h96, 8'h96);
    wait_dr(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout1 got no data_ready exp strobe");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("FAIL b2b_data1 got %h exp %h", out_data, exp); end
    end
    // Issue the next go during the data_ready cycle.
    in_data = 8'h5E;
    go = 1'b1;
    exp_q.push_back(8'h5E);
    tick();
    go = 1'b0;
    checks++;
    if (state !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b exp 1", state); end
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL b2b_dr_drop got %b exp 0", data_ready); end
    wait_dr(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout2 got no data_ready exp strobe");
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (out_data !== exp) begin errors++; $display("FAIL b2b_data2 got %h exp %h", out_data, exp); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int r0;
    logic [7:0] dropped;
    miso_mode = 0;
    r0 = dr_pulses;
    do_go(8'hC3, 8'hC3);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    dropped = exp_q.pop_back();
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL midrst_state got %b exp 0", state); end
    checks++;
    if (bp_din !== PINS_RESET) begin errors++; $display("FAIL midrst_pins got %b exp %b", bp_din, PINS_RESET); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_out got %h exp 00", out_data); end
    reset = 1'b0;
    repeat (50) tick();
    checks++;
    if (dr_pulses - r0 !== 0) begin errors++; $display("FAIL midrst_no_dr got %0d exp 0 (dropped %h)", dr_pulses - r0, dropped); end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] d, exp;
    miso_mode = 0;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom_range(0, 255));
      do_go(d, d);
      wait_dr(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand_timeout got no data_ready exp strobe");
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL rand_data got %h exp %h", out_data, exp); end
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_loopback();
    test_miso_one();
    test_pattern();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got %0d left exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
